// File: rtl/alu_pkg.sv
// Shared opcode encoding, condition-code layout and flag helper for the execute-stage ALU.
// The extended opcodes are only decoded when ALU_EXT_OPS_EN is defined.
package alu_pkg;

    // Widest datapath the flag helper supports; WIDTH must not exceed it.
    localparam int MAX_WIDTH = 128;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_XOR = 3'b011,
        OP_OR  = 3'b100,
        OP_SHL = 3'b101,
        OP_SAR = 3'b110,
        OP_RSV = 3'b111
    } op_e;

    typedef struct packed {
        logic zf;
        logic sf;
        logic of;
        logic cf;
    } cc_t;

    // r is the result zero-extended to MAX_WIDTH; returns {ZF, SF}.
    function automatic logic [1:0] zf_sf(input logic [MAX_WIDTH-1:0] r, input int unsigned width);
        return {(r == '0), r[width-1]};
    endfunction

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result, signed overflow, carry/borrow and illegal-op flag.
// No state; shifts (ALU_EXT_OPS_EN) use the low log2(WIDTH) bits of b as the amount.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] r,
    output logic             of,
    output logic             cf,
    output logic             illegal
);

    localparam int MSB = WIDTH - 1;

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    assign sum  = {1'b0, a} + {1'b0, b};
    assign diff = {1'b0, a} - {1'b0, b};

`ifdef ALU_EXT_OPS_EN
    localparam int SHW = $clog2(WIDTH);

    logic [SHW-1:0]     sh;
    logic [2*WIDTH-1:0] shl_full;
    logic [2*WIDTH-1:0] sar_full;

    // Double-width shifts keep the last bit shifted out at the half boundary.
    assign sh       = b[SHW-1:0];
    assign shl_full = {{WIDTH{1'b0}}, a} << sh;
    assign sar_full = $signed({a, {WIDTH{1'b0}}}) >>> sh;
`endif

    always_comb begin
        r       = '0;
        of      = 1'b0;
        cf      = 1'b0;
        illegal = 1'b0;
        case (op)
            OP_ADD: begin
                r  = sum[WIDTH-1:0];
                cf = sum[WIDTH];
                of = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            OP_SUB: begin
                r  = diff[WIDTH-1:0];
                cf = diff[WIDTH];
                of = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            OP_AND: r = a & b;
            OP_XOR: r = a ^ b;
`ifdef ALU_EXT_OPS_EN
            OP_OR:  r = a | b;
            OP_SHL: begin
                r  = shl_full[WIDTH-1:0];
                cf = shl_full[WIDTH];
            end
            OP_SAR: begin
                r  = sar_full[2*WIDTH-1:WIDTH];
                cf = sar_full[WIDTH-1];
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/alu_cc_pipe.sv
// Registered execute-stage ALU with architectural CC register; one cycle latency, valid/ready
// with in_ready = !out_valid || out_ready. Extended opcodes enabled by ALU_EXT_OPS_EN.
module alu_cc_pipe
    import alu_pkg::*;
#(
    parameter int          WIDTH    = 64,
    parameter logic [3:0]  CC_RESET = 4'b1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_set_cc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_of,
    output logic             out_illegal,
    output logic             cc_zf,
    output logic             cc_sf,
    output logic             cc_of,
    output logic             cc_cf
);

    logic [WIDTH-1:0] core_r;
    logic             core_of;
    logic             core_cf;
    logic             core_illegal;
    logic [1:0]       core_zs;
    logic             accept;
    cc_t              cc_q;

    alu_core #(.WIDTH(WIDTH)) u_core (
        .op      (in_op),
        .a       (in_a),
        .b       (in_b),
        .r       (core_r),
        .of      (core_of),
        .cf      (core_cf),
        .illegal (core_illegal)
    );

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign core_zs  = zf_sf(MAX_WIDTH'(core_r), WIDTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_result  <= '0;
            out_of      <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept) begin
            out_valid   <= 1'b1;
            out_result  <= core_r;
            out_of      <= core_of;
            out_illegal <= core_illegal;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

    // CC commits at accept, so a stalled result never delays the flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cc_q <= cc_t'(CC_RESET);
        end else if (accept && in_set_cc && !core_illegal) begin
            cc_q <= '{zf: core_zs[1], sf: core_zs[0], of: core_of, cf: core_cf};
        end
    end

    assign cc_zf = cc_q.zf;
    assign cc_sf = cc_q.sf;
    assign cc_of = cc_q.of;
    assign cc_cf = cc_q.cf;

endmodule

// File: tb/tb_alu_cc_pipe.sv
// Bench for alu_cc_pipe: 64-bit and 8-bit instances against an arithmetic reference model.
module tb_alu_cc_pipe;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        v64, irdy64, ov64, rdy64, scc64, of64, ill64, zf64, sf64, ofc64, cf64;
    logic [2:0]  op64;
    logic [63:0] a64, b64, r64;
    logic        v8, irdy8, ov8, rdy8, scc8, of8, ill8, zf8, sf8, ofc8, cf8;
    logic [2:0]  op8;
    logic [7:0]  a8, b8, r8;

    alu_cc_pipe #(.WIDTH(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(v64), .in_ready(irdy64), .in_op(op64),
        .in_a(a64), .in_b(b64), .in_set_cc(scc64), .out_valid(ov64), .out_ready(rdy64),
        .out_result(r64), .out_of(of64), .out_illegal(ill64),
        .cc_zf(zf64), .cc_sf(sf64), .cc_of(ofc64), .cc_cf(cf64)
    );

    alu_cc_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(v8), .in_ready(irdy8), .in_op(op8),
        .in_a(a8), .in_b(b8), .in_set_cc(scc8), .out_valid(ov8), .out_ready(rdy8),
        .out_result(r8), .out_of(of8), .out_illegal(ill8),
        .cc_zf(zf8), .cc_sf(sf8), .cc_of(ofc8), .cc_cf(cf8)
    );

    int checks = 0;
    int errors = 0;

    // Expected architectural state per unit (0: 64-bit, 1: 8-bit).
    logic        mv[2];
    logic [63:0] mr[2];
    logic        mof[2];
    logic        mill[2];
    logic [3:0]  mcc[2];

    typedef struct packed {
        logic [63:0] r;
        logic        of;
        logic        cf;
        logic        ill;
    } ref_t;

    function automatic logic signed [67:0] sx(input logic [63:0] v, input int w);
        logic signed [67:0] u;
        u = $signed({4'b0, v});
        return v[w-1] ? u - (68'sd1 <<< w) : u;
    endfunction

    // Reference: exact signed/unsigned integer arithmetic, then range tests for OF/CF.
    function automatic ref_t ref_alu(input int w, input logic [2:0] op, input logic [63:0] ain, input logic [63:0] bin);
        ref_t               o;
        logic [63:0]        mask, a, b, tmp;
        logic [64:0]        full;
        logic signed [67:0] s, hi, lo, sra;
        int                 n;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        a    = ain & mask;
        b    = bin & mask;
        hi   = (68'sd1 <<< (w - 1)) - 68'sd1;
        lo   = -(68'sd1 <<< (w - 1));
        n    = int'(b & 64'(w - 1));
        o    = '0;
        case (op)
            3'd0: begin
                full = {1'b0, a} + {1'b0, b};
                o.r  = full[63:0] & mask;
                o.cf = full[w];
                s    = sx(a, w) + sx(b, w);
                o.of = (s > hi) || (s < lo);
            end
            3'd1: begin
                o.r  = (a - b) & mask;
                o.cf = (a < b);
                s    = sx(a, w) - sx(b, w);
                o.of = (s > hi) || (s < lo);
            end
            3'd2: o.r = a & b;
            3'd3: o.r = a ^ b;
`ifdef ALU_EXT_OPS_EN
            3'd4: o.r = a | b;
            3'd5: begin
                o.r  = (a << n) & mask;
                tmp  = a >> (w - n);
                o.cf = (n != 0) && tmp[0];
            end
            3'd6: begin
                sra  = sx(a, w) >>> n;
                o.r  = sra[63:0] & mask;
                tmp  = a >> ((n == 0) ? 0 : n - 1);
                o.cf = (n != 0) && tmp[0];
            end
`endif
            default: o.ill = 1'b1;
        endcase
        return o;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic mdl_reset();
        for (int u = 0; u < 2; u++) begin
            mv[u] = 1'b0; mr[u] = '0; mof[u] = 1'b0; mill[u] = 1'b0; mcc[u] = 4'b1000;
        end
    endtask

    task automatic mdl_edge(input int u, input logic vld, input logic rdy, input logic [2:0] op,
                            input logic [63:0] a, input logic [63:0] b, input logic scc);
        ref_t o;
        logic zf, sf;
        if (vld && (!mv[u] || rdy)) begin
            o       = ref_alu((u == 0) ? 64 : 8, op, a, b);
            mv[u]   = 1'b1;
            mr[u]   = o.r;
            mof[u]  = o.of;
            mill[u] = o.ill;
            zf      = (o.r == 64'd0);
            sf      = (u == 0) ? o.r[63] : o.r[7];
            if (scc && !o.ill) mcc[u] = {zf, sf, o.of, o.cf};
        end else if (rdy) begin
            mv[u] = 1'b0;
        end
    endtask

    // One cycle on unit u, entered and left just after a falling edge.
    task automatic cyc(input int u, input logic vld, input logic [2:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic scc, input logic rdy);
        logic        o_irdy, o_v, o_of, o_ill;
        logic [63:0] o_r;
        logic [3:0]  o_cc;
        if (u == 0) begin
            v64 = vld; op64 = op; a64 = a; b64 = b; scc64 = scc; rdy64 = rdy; v8 = 1'b0; rdy8 = 1'b1;
        end else begin
            v8 = vld; op8 = op; a8 = a[7:0]; b8 = b[7:0]; scc8 = scc; rdy8 = rdy; v64 = 1'b0; rdy64 = 1'b1;
        end
        #1;
        o_irdy = (u == 0) ? irdy64 : irdy8;
        chk("in_ready", {63'd0, o_irdy}, {63'd0, (!mv[u] || rdy)});
        mdl_edge(0, v64, rdy64, op64, a64, b64, scc64);
        mdl_edge(1, v8, rdy8, op8, {56'd0, a8}, {56'd0, b8}, scc8);
        @(posedge clk);
        @(negedge clk);
        o_v   = (u == 0) ? ov64 : ov8;
        o_r   = (u == 0) ? r64 : {56'd0, r8};
        o_of  = (u == 0) ? of64 : of8;
        o_ill = (u == 0) ? ill64 : ill8;
        o_cc  = (u == 0) ? {zf64, sf64, ofc64, cf64} : {zf8, sf8, ofc8, cf8};
        chk("out_valid", {63'd0, o_v}, {63'd0, mv[u]});
        chk("cc", {60'd0, o_cc}, {60'd0, mcc[u]});
        if (mv[u]) begin
            chk("out_result", o_r, mr[u]);
            chk("out_of", {63'd0, o_of}, {63'd0, mof[u]});
            chk("out_illegal", {63'd0, o_ill}, {63'd0, mill[u]});
        end
    endtask

    initial begin
        logic [63:0] ra, rb;
        rst_n = 1'b0;
        v64 = 0; op64 = 0; a64 = 0; b64 = 0; scc64 = 0; rdy64 = 1;
        v8 = 0; op8 = 0; a8 = 0; b8 = 0; scc8 = 0; rdy8 = 1;
        mdl_reset();
        repeat (2) @(negedge clk);
        chk("rst_valid", {63'd0, ov64}, 64'd0);
        chk("rst_ready", {63'd0, irdy64}, 64'd1);
        chk("rst_result", r64, 64'd0);
        chk("rst_flags", {62'd0, of64, ill64}, 64'd0);
        chk("rst_cc", {60'd0, zf64, sf64, ofc64, cf64}, 64'h8);
        rst_n = 1'b1;

        cyc(0, 1, OP_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1, 1);
        chk("add_ovf_res", r64, 64'h8000_0000_0000_0000);
        chk("add_ovf_of", {63'd0, of64}, 64'd1);
        chk("add_ovf_cc", {60'd0, zf64, sf64, ofc64, cf64}, 64'h6);
        cyc(0, 1, OP_SUB, 64'd5, 64'd5, 1, 1);
        chk("sub_zero_cc", {60'd0, zf64, sf64, ofc64, cf64}, 64'h8);
        cyc(0, 1, OP_SUB, 64'd3, 64'd5, 0, 1);
        chk("sub_neg_res", r64, 64'hFFFF_FFFF_FFFF_FFFE);
        chk("sub_nocc", {60'd0, zf64, sf64, ofc64, cf64}, 64'h8);

        // Back-pressure: first op held, second stalls, then drain+accept together.
        cyc(0, 1, OP_AND, 64'hF0F0, 64'hFF00, 0, 1);
        cyc(0, 1, OP_XOR, 64'h1234, 64'h4321, 1, 0);
        chk("bp_stall_ready", {63'd0, irdy64}, 64'd0);
        cyc(0, 1, OP_XOR, 64'h1234, 64'h4321, 1, 0);
        chk("bp_hold_res", r64, 64'hF000);
        cyc(0, 1, OP_XOR, 64'h1234, 64'h4321, 1, 1);
        chk("bp_new_res", r64, 64'h5115);
        cyc(0, 0, OP_ADD, 64'd0, 64'd0, 0, 1);
        chk("bp_drained", {63'd0, ov64}, 64'd0);

        cyc(0, 1, OP_RSV, 64'd9, 64'd9, 1, 1);
        chk("ill_flag", {63'd0, ill64}, 64'd1);
        chk("ill_res", r64, 64'd0);
`ifdef ALU_EXT_OPS_EN
        cyc(0, 1, OP_SAR, 64'h8000_0000_0000_0000, 64'd63, 1, 1);
        chk("sar_res", r64, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("sar_cf", {63'd0, cf64}, 64'd0);
        cyc(0, 1, OP_SHL, 64'hC000_0000_0000_0001, 64'd1, 1, 1);
`else
        cyc(0, 1, OP_OR, 64'd1, 64'd2, 1, 1);
        chk("or_illegal", {63'd0, ill64}, 64'd1);
`endif

        // Asynchronous reset while a result is stalled.
        cyc(0, 1, OP_ADD, 64'd1, 64'd2, 1, 0);
        v64 = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, ov64}, 64'd0);
        chk("arst_cc", {60'd0, zf64, sf64, ofc64, cf64}, 64'h8);
        mdl_reset();
        @(negedge clk);
        rst_n = 1'b1;

        cyc(1, 1, OP_ADD, 64'hFF, 64'h01, 1, 1);
        chk("w8_add_res", {56'd0, r8}, 64'd0);
        chk("w8_add_cc", {60'd0, zf8, sf8, ofc8, cf8}, 64'h9);
        cyc(1, 1, OP_XOR, 64'hAA, 64'hAA, 1, 1);
        chk("w8_xor_zf", {63'd0, zf8}, 64'd1);

        for (int i = 0; i < 400; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: ra = '0;
                1: rb = ra;
                2: ra = 64'h8000_0000_0000_0000;
                3: rb = 64'hFFFF_FFFF_FFFF_FFFF;
                default: ;
            endcase
            cyc(0, $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), ra, rb,
                1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 200; i++) begin
            ra = 64'($urandom_range(0, 255));
            rb = (i % 5 == 0) ? ra : 64'($urandom_range(0, 255));
            cyc(1, $urandom_range(0, 9) < 7, 3'($urandom_range(0, 7)), ra, rb,
                1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
